// File: rtl/spi_scene_loader.sv
// Packet parser sitting between the SPI 64-bit word accumulator and the
// raytracing controller. Frames incoming words into scene/camera packets,
// streams sphere records into the scene RAM, and commits the object count
// or camera word only when the XOR trailer checks out.
module spi_scene_loader #(
  parameter int MAX_OBJ     = 16,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              i_dv,
  input  logic [63:0]       i_word,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [127:0]      o_wr_data,
  output logic [7:0]        o_obj_count,
  output logic [63:0]       o_cam_data,
  output logic              o_frame_dv,
  output logic              o_busy,
  output logic              o_err,
  output logic [2:0]        o_err_code,
  output logic              o_irq
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_OPCODE  = 3'd2;
  localparam logic [2:0] ERR_COUNT   = 3'd3;
  localparam logic [2:0] ERR_TRAILER = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  localparam logic [7:0] MAGIC     = 8'hA5;
  localparam logic [7:0] OP_SCENE  = 8'h01;
  localparam logic [7:0] OP_CAMERA = 8'h02;

  typedef enum logic [2:0] {IDLE, OBJ_LO, OBJ_HI, CAM, TRAILER} state_t;

  state_t            state;
  logic [63:0]       csum;
  logic [63:0]       lo_word;
  logic [63:0]       cam_shadow;
  logic [7:0]        obj_idx;
  logic [7:0]        obj_n;
  logic              is_scene;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [7:0]        hdr_magic;
  logic [7:0]        hdr_op;
  logic [7:0]        hdr_n;
  logic              err_hit;
  logic [2:0]        err_cause;

  assign hdr_magic = i_word[63:56];
  assign hdr_op    = i_word[55:48];
  assign hdr_n     = i_word[47:40];

  // Decide whether this cycle aborts the packet, and why.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    err_hit   = 1'b0;
    err_cause = ERR_NONE;
    if (state == IDLE) begin
      if (i_dv) begin
        if (hdr_magic != MAGIC) begin
          err_hit   = 1'b1;
          err_cause = ERR_MAGIC;
        end else if (hdr_op != OP_SCENE && hdr_op != OP_CAMERA) begin
          err_hit   = 1'b1;
          err_cause = ERR_OPCODE;
        end else if (hdr_op == OP_SCENE && (hdr_n == 8'd0 || hdr_n > 8'(MAX_OBJ))) begin
          err_hit   = 1'b1;
          err_cause = ERR_COUNT;
        end
      end
    end else if (i_dv) begin
      if (state == TRAILER && i_word != csum) begin
        err_hit   = 1'b1;
        err_cause = ERR_TRAILER;
      end
    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
      err_hit   = 1'b1;
      err_cause = ERR_TIMEOUT;
    end
  end

  // Packet FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_) begin
    // NOTE: the small datapath registers (checksum, shadows) are reset too; there is no RAM array here to exempt.
    if (!rst_) begin
      state       <= IDLE;
      csum        <= '0;
      lo_word     <= '0;
      cam_shadow  <= '0;
      obj_idx     <= '0;
      obj_n       <= '0;
      is_scene    <= 1'b0;
      tmo_cnt     <= '0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_obj_count <= '0;
      o_cam_data  <= '0;
      o_frame_dv  <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_irq       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      o_wr_en    <= 1'b0;
      o_frame_dv <= 1'b0;
      o_err      <= 1'b0;

      if (err_hit) begin
        state      <= IDLE;
        o_busy     <= 1'b0;
        o_err      <= 1'b1;
        o_err_code <= err_cause;
        o_irq      <= 1'b1;
        tmo_cnt    <= '0;
      end else if (i_dv) begin
        tmo_cnt <= '0;
        unique case (state)
          IDLE: begin
            csum       <= '0;
            obj_idx    <= '0;
            obj_n      <= hdr_n;
            is_scene   <= (hdr_op == OP_SCENE);
            o_err_code <= ERR_NONE;
            o_irq      <= 1'b0;
            o_busy     <= 1'b1;
            state      <= (hdr_op == OP_SCENE) ? OBJ_LO : CAM;
          end
          OBJ_LO: begin
            lo_word <= i_word;
            csum    <= csum ^ i_word;
            state   <= OBJ_HI;
          end
          OBJ_HI: begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= obj_idx[ADDR_W-1:0];
            o_wr_data <= {lo_word, i_word};
            csum      <= csum ^ i_word;
            obj_idx   <= obj_idx + 8'd1;
            state     <= (obj_idx + 8'd1 == obj_n) ? TRAILER : OBJ_LO;
          end
          CAM: begin
            cam_shadow <= i_word;
            csum       <= csum ^ i_word;
            state      <= TRAILER;
          end
          TRAILER: begin
            // Only reached on a matching trailer; mismatches are caught above.
            if (is_scene) o_obj_count <= obj_n;
            else          o_cam_data  <= cam_shadow;
            o_frame_dv <= 1'b1;
            o_irq      <= 1'b1;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_scene_loader.sv
// Self-checking bench for spi_scene_loader: directed scenarios plus
// randomized packets judged by a packet-level reference model.
module tb_spi_scene_loader;

  localparam int MAX_OBJ = 16;
  localparam int ADDR_W  = 4;
  localparam int TMO     = 40;

  typedef logic [63:0] word_q_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [127:0]      data;
  } wr_t;

  logic              clk;
  logic              rst_;
  logic              i_dv;
  logic [63:0]       i_word;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [127:0]      o_wr_data;
  logic [7:0]        o_obj_count;
  logic [63:0]       o_cam_data;
  logic              o_frame_dv;
  logic              o_busy;
  logic              o_err;
  logic [2:0]        o_err_code;
  logic              o_irq;

  spi_scene_loader #(.MAX_OBJ(MAX_OBJ), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_(rst_), .i_dv(i_dv), .i_word(i_word),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_obj_count(o_obj_count), .o_cam_data(o_cam_data), .o_frame_dv(o_frame_dv),
    .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code), .o_irq(o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed events, gathered on the falling edge while out of reset.
  wr_t wr_q[$];
  int  frame_cnt;
  int  err_cnt;
  bit  busy_seen;

  always @(negedge clk) begin
    if (rst_) begin
      if (o_wr_en) wr_q.push_back('{addr: o_wr_addr, data: o_wr_data});
      if (o_frame_dv) frame_cnt++;
      if (o_err) err_cnt++;
      if (o_busy) busy_seen = 1'b1;
    end
  end

  // Reference model state: what the MCU should currently observe.
  logic [7:0]  m_count;
  logic [63:0] m_cam;
  logic [2:0]  m_code;
  logic        m_irq;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send_word(input logic [63:0] w, input int gap);
    repeat (gap) @(negedge clk);
    i_dv   = 1'b1;
    i_word = w;
    @(negedge clk);
    i_dv   = 1'b0;
    i_word = rnd64();
  endtask

  task automatic clear_obs();
    wr_q.delete();
    frame_cnt = 0;
    err_cnt   = 0;
    busy_seen = 1'b0;
  endtask

  // Send a whole packet, then judge it against the packet-level rules.
  task automatic run_packet(input string name, input word_q_t pkt, input int max_gap);
    wr_t         ew[$];
    logic [7:0]  magic, op, n;
    logic [63:0] x;
    int          pc;
    int          code;
    int          exp_frame;
    bit          hdr_ok;

    clear_obs();
    foreach (pkt[i]) send_word(pkt[i], $urandom_range(0, max_gap));
    repeat (2) @(negedge clk);

    magic     = pkt[0][63:56];
    op        = pkt[0][55:48];
    n         = pkt[0][47:40];
    code      = 0;
    exp_frame = 0;
    hdr_ok    = 1'b0;
    if (magic != 8'hA5)                                   code = 1;
    else if (op != 8'h01 && op != 8'h02)                  code = 2;
    else if (op == 8'h01 && (n == 0 || n > MAX_OBJ))      code = 3;
    else begin
      hdr_ok = 1'b1;
      pc = (op == 8'h01) ? 2 * n : 1;
      x  = '0;
      for (int i = 1; i <= pc; i++) x ^= pkt[i];
      if (op == 8'h01)
        for (int k = 0; k < n; k++)
          ew.push_back('{addr: ADDR_W'(k), data: {pkt[1 + 2*k], pkt[2 + 2*k]}});
      if (pkt[pc + 1] == x) begin
        exp_frame = 1;
        if (op == 8'h01) m_count = n;
        else             m_cam   = pkt[1];
      end else begin
        code = 4;
      end
    end
    m_code = 3'(code);
    m_irq  = 1'b1;

    check({name, ":wr_n"}, wr_q.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wr_q.size(); i++) begin
      check($sformatf("%s:wr_addr%0d", name, i), wr_q[i].addr, ew[i].addr);
      check($sformatf("%s:wr_data%0d", name, i), wr_q[i].data, ew[i].data);
    end
    check({name, ":frame_n"}, frame_cnt, exp_frame);
    check({name, ":err_n"}, err_cnt, (code != 0) ? 1 : 0);
    check({name, ":err_code"}, o_err_code, m_code);
    check({name, ":obj_count"}, o_obj_count, m_count);
    check({name, ":cam"}, o_cam_data, m_cam);
    check({name, ":irq"}, o_irq, m_irq);
    check({name, ":busy_end"}, o_busy, 1'b0);
    check({name, ":busy_seen"}, busy_seen, hdr_ok);
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] magic, input logic [7:0] op, input logic [7:0] n);
    return {magic, op, n, 40'(rnd64())};
  endfunction

  // Well-formed scene packet with n objects; optionally corrupt the trailer.
  function automatic word_q_t scene_pkt(input int n, input bit bad_trl);
    word_q_t     p;
    logic [63:0] w, x;
    x = '0;
    p.push_back(hdr(8'hA5, 8'h01, 8'(n)));
    for (int i = 0; i < 2 * n; i++) begin
      w = rnd64();
      x ^= w;
      p.push_back(w);
    end
    if (bad_trl) x ^= (64'd1 << $urandom_range(0, 63));
    p.push_back(x);
    return p;
  endfunction

  function automatic word_q_t cam_pkt(input bit bad_trl);
    word_q_t     p;
    logic [63:0] w, t;
    w = rnd64();
    t = bad_trl ? (w ^ (64'd1 << $urandom_range(0, 63))) : w;
    p.push_back(hdr(8'hA5, 8'h02, 8'($urandom)));
    p.push_back(w);
    p.push_back(t);
    return p;
  endfunction

  task automatic check_all_zero(input string name);
    check({name, ":wr_en"}, o_wr_en, 1'b0);
    check({name, ":wr_addr"}, o_wr_addr, '0);
    check({name, ":wr_data"}, o_wr_data, '0);
    check({name, ":obj_count"}, o_obj_count, '0);
    check({name, ":cam"}, o_cam_data, '0);
    check({name, ":frame_dv"}, o_frame_dv, 1'b0);
    check({name, ":busy"}, o_busy, 1'b0);
    check({name, ":err"}, o_err, 1'b0);
    check({name, ":err_code"}, o_err_code, '0);
    check({name, ":irq"}, o_irq, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b, c, d;
    word_q_t     p;
    int          cyc;
    int          kind;
    logic [7:0]  v;

    rst_   = 1'b0;
    i_dv   = 1'b0;
    i_word = '0;
    m_count = '0; m_cam = '0; m_code = '0; m_irq = 1'b0;
    clear_obs();
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Scene N=2, back-to-back, with cycle-exact latency checks.
    a = rnd64(); b = rnd64(); c = rnd64(); d = rnd64();
    send_word(hdr(8'hA5, 8'h01, 8'd2), 0);
    check("s2:busy_hdr", o_busy, 1'b1);
    send_word(a, 0);
    send_word(b, 0);
    check("s2:wr_en0", o_wr_en, 1'b1);
    check("s2:addr0", o_wr_addr, 4'd0);
    check("s2:data0", o_wr_data, {a, b});
    send_word(c, 0);
    check("s2:wr_idle", o_wr_en, 1'b0);
    send_word(d, 0);
    check("s2:wr_en1", o_wr_en, 1'b1);
    check("s2:addr1", o_wr_addr, 4'd1);
    check("s2:data1", o_wr_data, {c, d});
    send_word(a ^ b ^ c ^ d, 0);
    check("s2:frame_dv", o_frame_dv, 1'b1);
    check("s2:obj_count", o_obj_count, 8'd2);
    check("s2:irq", o_irq, 1'b1);
    check("s2:busy", o_busy, 1'b0);
    @(negedge clk);
    check("s2:frame_pulse", o_frame_dv, 1'b0);
    m_count = 8'd2; m_irq = 1'b1; m_code = '0;

    // Camera packet; object count must stay put.
    p = {hdr(8'hA5, 8'h02, 8'h00), 64'h1234, 64'h1234};
    run_packet("cam", p, 1);

    // Bad magic, then a normal packet.
    p = {hdr(8'h5A, 8'h01, 8'd2)};
    run_packet("magic", p, 0);
    run_packet("after_magic", scene_pkt(1, 1'b0), 1);

    // Count boundaries.
    p = {hdr(8'hA5, 8'h01, 8'(MAX_OBJ + 1))};
    run_packet("n_over", p, 0);
    p = {hdr(8'hA5, 8'h01, 8'd0)};
    run_packet("n_zero", p, 0);
    run_packet("n_max", scene_pkt(MAX_OBJ, 1'b0), 0);

    // Bad trailer after a committed N=3.
    run_packet("n3", scene_pkt(3, 1'b0), 1);
    run_packet("bad_trl", scene_pkt(5, 1'b1), 1);

    // Stall mid-payload until the timeout fires.
    clear_obs();
    send_word(hdr(8'hA5, 8'h01, 8'd3), 0);
    send_word(rnd64(), 0);
    cyc = 0;
    while (!o_err && cyc < TMO + 20) begin
      @(negedge clk);
      cyc++;
    end
    check("tmo:fired", o_err, 1'b1);
    check("tmo:window", (cyc >= TMO - 1 && cyc <= TMO + 1), 1'b1);
    check("tmo:code", o_err_code, 3'd5);
    check("tmo:busy", o_busy, 1'b0);
    check("tmo:irq", o_irq, 1'b1);
    check("tmo:count", o_obj_count, m_count);
    @(negedge clk);
    check("tmo:err_pulse", o_err, 1'b0);
    m_code = 3'd5;

    // Asynchronous reset while in OBJ_HI.
    send_word(hdr(8'hA5, 8'h01, 8'd2), 0);
    send_word(rnd64(), 0);
    #2 rst_ = 1'b0;
    #1 check_all_zero("rst_mid");
    m_count = '0; m_cam = '0; m_code = '0; m_irq = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    run_packet("after_rst", scene_pkt(2, 1'b0), 1);

    // Randomized packet mix.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1: p = scene_pkt($urandom_range(1, MAX_OBJ), 1'b0);
        2:    p = cam_pkt(1'b0);
        3: begin
          v = 8'($urandom);
          if (v == 8'hA5) v = 8'h00;
          p = {hdr(v, 8'h01, 8'd1)};
        end
        4: begin
          v = 8'($urandom);
          if (v == 8'h01 || v == 8'h02) v = 8'h03;
          p = {hdr(8'hA5, v, 8'd1)};
        end
        5: begin
          v = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(MAX_OBJ + 1, 255));
          p = {hdr(8'hA5, 8'h01, v)};
        end
        default: p = ($urandom_range(0, 1) == 1) ? scene_pkt($urandom_range(1, MAX_OBJ), 1'b1)
                                                 : cam_pkt(1'b1);
      endcase
      run_packet($sformatf("rnd%0d", t), p, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
